melee_attack_ctrl: RTL and testbench

Sequences melee attacks for the player weapon. It buffers mouse clicks, schedules one swing at a time, and gates swings with a cooldown. It also opens a frame-accurate hit window and issues exactly one damage request per swing to the boss-HP block over a valid/ready handshake. Its anim_trigger output replaces the raw mouse click into the melee swing animator, so the animation and damage stay in lockstep.

---
 rtl/melee_attack_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_melee_attack_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melee_attack_ctrl.sv
// melee_attack_ctrl: buffers clicks, sequences swing/cooldown, issues one damage request per swing.
// Optional feature macro: MELEE_COMBO_EN (combo level scales damage).
module melee_attack_ctrl #(
  parameter int SWING_FRAMES    = 12,
  parameter int HIT_START       = 3,
  parameter int HIT_END         = 8,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int QUEUE_DEPTH     = 2,
  parameter int DAMAGE          = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       mouse_clicked,
  input  logic       alive,
  input  logic       boss_hit,
  input  logic       dmg_ready,
  output logic       anim_trigger,
  output logic       swing_start,
  output logic       hit_window,
  output logic       dmg_valid,
  output logic [3:0] dmg_amount,
  output logic [7:0] frame_idx,
  output logic [2:0] pend_cnt,
  output logic [1:0] combo
);

  typedef enum logic [1:0] {
    IDLE,
    SWING,
    COOLDOWN
  } state_e;

  localparam logic [7:0] LAST_FRAME = 8'(SWING_FRAMES - 1);
  localparam logic [7:0] HIT_LO     = 8'(HIT_START);
  localparam logic [7:0] HIT_HI     = 8'(HIT_END);
  localparam logic [7:0] CD_LAST    = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [2:0] QD         = 3'(QUEUE_DEPTH);
  localparam logic [3:0] DMG        = 4'(DAMAGE);

  state_e     state_q, state_d;
  logic [7:0] frame_idx_q, frame_idx_d;
  logic [7:0] cd_cnt_q, cd_cnt_d;
  logic [2:0] pend_cnt_q, pend_cnt_d;
  logic       click_q;
  logic       swing_start_q, swing_start_d;
  logic       dmg_valid_q, dmg_valid_d;
  logic [3:0] dmg_amount_q, dmg_amount_d;
  logic       dmg_done_q, dmg_done_d;

`ifdef MELEE_COMBO_EN
  logic [1:0] combo_q, combo_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       had_cd_q, had_cd_d;
`endif

  logic click_pulse;
  logic inc;
  logic consume;
  logic in_win;
  logic issue;

  assign click_pulse = mouse_clicked & ~click_q;
  assign inc         = alive & click_pulse;
  assign consume     = (state_q == IDLE) & frame_tick
                     & (pend_cnt_q != 3'd0);

  assign in_win = (state_q == SWING)
                & (frame_idx_q >= HIT_LO)
                & (frame_idx_q <= HIT_HI);
  assign issue  = in_win & boss_hit
                & ~dmg_done_q & ~dmg_valid_q;

  always_comb begin
    state_d       = state_q;
    frame_idx_d   = frame_idx_q;
    cd_cnt_d      = cd_cnt_q;
    pend_cnt_d    = pend_cnt_q;
    swing_start_d = 1'b0;
    dmg_valid_d   = dmg_valid_q;
    dmg_amount_d  = dmg_amount_q;
    dmg_done_d    = dmg_done_q;
`ifdef MELEE_COMBO_EN
    combo_d       = combo_q;
    idle_cnt_d    = idle_cnt_q;
    had_cd_d      = had_cd_q;
`endif

    // a click landing on a consume cancels out, even when full
    if (inc && !consume) begin
      if (pend_cnt_q != QD) pend_cnt_d = pend_cnt_q + 3'd1;
    end else if (!inc && consume) begin
      pend_cnt_d = pend_cnt_q - 3'd1;
    end

    if (dmg_valid_q && dmg_ready) begin
      dmg_valid_d = 1'b0;
    end else if (issue) begin
      dmg_valid_d = 1'b1;
      dmg_done_d  = 1'b1;
`ifdef MELEE_COMBO_EN
      dmg_amount_d = DMG + {2'b00, combo_q};
`else
      dmg_amount_d = DMG;
`endif
    end

    if (frame_tick) begin
      unique case (state_q)
        IDLE: begin
          if (consume) begin
            state_d       = SWING;
            frame_idx_d   = 8'd0;
            dmg_done_d    = 1'b0;
            swing_start_d = 1'b1;
`ifdef MELEE_COMBO_EN
            if (had_cd_q && idle_cnt_q < 4'd8) begin
              if (combo_q != 2'd3) combo_d = combo_q + 2'd1;
            end else begin
              combo_d = 2'd0;
            end
            had_cd_d = 1'b0;
`endif
          end else begin
`ifdef MELEE_COMBO_EN
            if (idle_cnt_q == 4'd7) begin
              combo_d  = 2'd0;
              had_cd_d = 1'b0;
            end
            if (idle_cnt_q != 4'd8) idle_cnt_d = idle_cnt_q + 4'd1;
`endif
          end
        end
        SWING: begin
          if (frame_idx_q == LAST_FRAME) begin
            state_d     = COOLDOWN;
            cd_cnt_d    = 8'd0;
            frame_idx_d = 8'd0;
          end else begin
            frame_idx_d = frame_idx_q + 8'd1;
          end
        end
        COOLDOWN: begin
          if (cd_cnt_q == CD_LAST) begin
            state_d = IDLE;
`ifdef MELEE_COMBO_EN
            idle_cnt_d = 4'd0;
            had_cd_d   = 1'b1;
`endif
          end else begin
            cd_cnt_d = cd_cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // death wipes the swing sequence and any pending request
    if (!alive) begin
      state_d       = IDLE;
      frame_idx_d   = 8'd0;
      cd_cnt_d      = 8'd0;
      pend_cnt_d    = 3'd0;
      swing_start_d = 1'b0;
      dmg_valid_d   = 1'b0;
      dmg_done_d    = 1'b0;
`ifdef MELEE_COMBO_EN
      combo_d       = 2'd0;
      idle_cnt_d    = 4'd0;
      had_cd_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      frame_idx_q   <= 8'd0;
      cd_cnt_q      <= 8'd0;
      pend_cnt_q    <= 3'd0;
      click_q       <= 1'b0;
      swing_start_q <= 1'b0;
      dmg_valid_q   <= 1'b0;
      dmg_amount_q  <= 4'd0;
      dmg_done_q    <= 1'b0;
`ifdef MELEE_COMBO_EN
      combo_q       <= 2'd0;
      idle_cnt_q    <= 4'd0;
      had_cd_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      frame_idx_q   <= frame_idx_d;
      cd_cnt_q      <= cd_cnt_d;
      pend_cnt_q    <= pend_cnt_d;
      click_q       <= mouse_clicked;
      swing_start_q <= swing_start_d;
      dmg_valid_q   <= dmg_valid_d;
      dmg_amount_q  <= dmg_amount_d;
      dmg_done_q    <= dmg_done_d;
`ifdef MELEE_COMBO_EN
      combo_q       <= combo_d;
      idle_cnt_q    <= idle_cnt_d;
      had_cd_q      <= had_cd_d;
`endif
    end
  end

  assign anim_trigger = (state_q == SWING);
  assign swing_start  = swing_start_q;
  assign hit_window   = in_win;
  assign dmg_valid    = dmg_valid_q;
  assign dmg_amount   = dmg_amount_q;
  assign frame_idx    = frame_idx_q;
  assign pend_cnt     = pend_cnt_q;
`ifdef MELEE_COMBO_EN
  assign combo        = combo_q;
`else
  assign combo        = 2'd0;
`endif

endmodule

// File: tb/tb_melee_attack_ctrl.sv
// tb_melee_attack_ctrl: directed vectors for melee_attack_ctrl.
// Combo checks are compiled in when MELEE_COMBO_EN is defined.
module tb_melee_attack_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       mouse_clicked = 1'b0;
  logic       alive = 1'b1;
  logic       boss_hit = 1'b0;
  logic       dmg_ready = 1'b0;
  logic       anim_trigger;
  logic       swing_start;
  logic       hit_window;
  logic       dmg_valid;
  logic [3:0] dmg_amount;
  logic [7:0] frame_idx;
  logic [2:0] pend_cnt;
  logic [1:0] combo;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [3:0] last_amt = 4'd0;

  melee_attack_ctrl dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .mouse_clicked(mouse_clicked),
    .alive(alive),
    .boss_hit(boss_hit),
    .dmg_ready(dmg_ready),
    .anim_trigger(anim_trigger),
    .swing_start(swing_start),
    .hit_window(hit_window),
    .dmg_valid(dmg_valid),
    .dmg_amount(dmg_amount),
    .frame_idx(frame_idx),
    .pend_cnt(pend_cnt),
    .combo(combo)
  );

  always #5 clk = ~clk;

  // completed handshakes
  always @(posedge clk) begin
    if (!rst && dmg_valid && dmg_ready) begin
      n_acc    <= n_acc + 1;
      last_amt <= dmg_amount;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ft();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic click();
    mouse_clicked = 1'b1;
    step();
    mouse_clicked = 1'b0;
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      ft();
      step();
    end
  endtask

  task automatic run_to_start(input string tag, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      ft();
      n++;
      if (swing_start) seen = 1'b1;
      step();
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic count_starts(input int n, output int s);
    s = 0;
    for (int i = 0; i < n; i++) begin
      ft();
      if (swing_start) s++;
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hits, bad, s, acc0;

    // reset values
    step();
    step();
    chk("rst_anim", anim_trigger, 0);
    chk("rst_start", swing_start, 0);
    chk("rst_hit", hit_window, 0);
    chk("rst_valid", dmg_valid, 0);
    chk("rst_amt", dmg_amount, 0);
    chk("rst_frame", frame_idx, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_combo", combo, 0);
    rst = 1'b0;
    step();

    // 1: single swing with boss overlapping
    boss_hit = 1'b1;
    dmg_ready = 1'b1;
    click();
    chk("s1_pend1", pend_cnt, 1);
    ft();
    chk("s1_start", swing_start, 1);
    chk("s1_anim", anim_trigger, 1);
    chk("s1_frame0", frame_idx, 0);
    chk("s1_pend0", pend_cnt, 0);
    step();
    chk("s1_start_pulse", swing_start, 0);
    hits = 0;
    bad = 0;
    for (int f = 1; f < 12; f++) begin
      ft();
      if (frame_idx != 8'(f)) bad++;
      hits += int'(hit_window);
      step();
    end
    chk("s1_frame_seq", bad, 0);
    chk("s1_hit_frames", hits, 6);
    ft();
    chk("s1_cd_anim", anim_trigger, 0);
    chk("s1_cd_frame", frame_idx, 0);
    chk("s1_acc", n_acc, 1);
    chk("s1_amt", last_amt, 1);
    chk("s1_valid_clr", dmg_valid, 0);
    step();
    click();
    run_to_start("s1_cd", n);
    chk("s1_cd_gap", n, 7);

    // 2: queue saturation and spacing
    for (int i = 0; i < 4; i++) click();
    chk("s2_sat", pend_cnt, 2);
    run_to_start("s2_a", n);
    chk("s2_gap_a", n, 19);
    chk("s2_pend_a", pend_cnt, 1);
`ifndef MELEE_COMBO_EN
    chk("s2_combo_off", combo, 0);
`endif
    run_to_start("s2_b", n);
    chk("s2_gap_b", n, 19);
    chk("s2_pend_b", pend_cnt, 0);
    count_starts(40, s);
    chk("s2_no_extra", s, 0);
    chk("s2_one_per_swing", n_acc, 4);

    // 3: stalled handshake
    dmg_ready = 1'b0;
    click();
    run_to_start("s3", n);
    frames(3);
    chk("s3_valid", dmg_valid, 1);
    chk("s3_amt", dmg_amount, 1);
    acc0 = n_acc;
    click();
    bad = 0;
    s = 0;
    for (int i = 0; i < 40; i++) begin
      ft();
      if (swing_start) s++;
      if (dmg_valid !== 1'b1 || dmg_amount !== 4'd1) bad++;
      step();
      if (dmg_valid !== 1'b1 || dmg_amount !== 4'd1) bad++;
    end
    chk("s3_stable", bad, 0);
    chk("s3_second_swing", s, 1);
    dmg_ready = 1'b1;
    step();
    chk("s3_release", dmg_valid, 0);
    repeat (5) step();
    chk("s3_no_reissue", dmg_valid, 0);
    chk("s3_acc", n_acc - acc0, 1);

    // 4: death mid-swing
    dmg_ready = 1'b0;
    click();
    run_to_start("s4", n);
    click();
    click();
    frames(5);
    chk("s4_pre_frame", frame_idx, 5);
    chk("s4_pre_valid", dmg_valid, 1);
    chk("s4_pre_pend", pend_cnt, 2);
    alive = 1'b0;
    step();
    chk("s4_frame", frame_idx, 0);
    chk("s4_pend", pend_cnt, 0);
    chk("s4_valid", dmg_valid, 0);
    chk("s4_anim", anim_trigger, 0);
    click();
    click();
    chk("s4_dead_click", pend_cnt, 0);
    ft();
    chk("s4_dead_idle", anim_trigger, 0);
    step();
    alive = 1'b1;
    dmg_ready = 1'b1;
    step();

    // 5: click coinciding with consume
    boss_hit = 1'b0;
    click();
    chk("s5_pre", pend_cnt, 1);
    mouse_clicked = 1'b1;
    frame_tick = 1'b1;
    step();
    chk("s5_start", swing_start, 1);
    chk("s5_pend", pend_cnt, 1);
    mouse_clicked = 1'b0;
    frame_tick = 1'b0;
    step();

    // async reset mid-request
    boss_hit = 1'b1;
    dmg_ready = 1'b0;
    frames(4);
    chk("ar_pre_valid", dmg_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_valid", dmg_valid, 0);
    chk("ar_anim", anim_trigger, 0);
    chk("ar_pend", pend_cnt, 0);
    chk("ar_frame", frame_idx, 0);
    chk("ar_amt", dmg_amount, 0);
    step();
    rst = 1'b0;
    dmg_ready = 1'b1;
    step();

`ifdef MELEE_COMBO_EN
    // 6: combo across queued swings
    click();
    run_to_start("s6_a", n);
    chk("s6_combo0", combo, 0);
    click();
    click();
    run_to_start("s6_b", n);
    chk("s6_combo1", combo, 1);
    chk("s6_amt1", last_amt, 1);
    run_to_start("s6_c", n);
    chk("s6_combo2", combo, 2);
    chk("s6_amt2", last_amt, 2);
    frames(18);
    chk("s6_amt3", last_amt, 3);
    frames(7);
    chk("s6_combo_hold", combo, 2);
    frames(1);
    chk("s6_combo_clr", combo, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
